// File: rtl/ht_pkg.sv
// Shared definitions for the integer Haar transform pair (ht / iht_inv).
// Holds the controller state encoding and stage-counter sizing.
package ht_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int cnt_w(input int iw);
        return (iw > 1) ? $clog2(iw) : 1;
    endfunction

endpackage

// File: rtl/iht_butterfly.sv
// One inverse lifting step: recovers the sample pair (a, b)
// from a smooth/detail pair (s, d), modulo 2**width.
module iht_butterfly #(
    parameter int width = 8
) (
    input  logic [width-1:0] s,
    input  logic [width-1:0] d,
    output logic [width-1:0] a,
    output logic [width-1:0] b
);

    logic [width-1:0] d_half;

    assign d_half = $unsigned($signed(d) >>> 1);
    assign b      = s - d_half;
    assign a      = d + b;

endmodule

// File: rtl/iht_inv.sv
// Iterative inverse integer Haar transform, one lifting stage per
// clock, from Mallat-ordered coefficients back to samples.
module iht_inv
    import ht_pkg::*;
#(
    parameter int index       = 8,
    parameter int width       = 8,
    parameter int index_width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width-1:0] indata  [0:index-1],
    output logic [width-1:0] outdata [0:index-1],
    output logic             busy,
    output logic             over
);

    localparam int HALF = index / 2;
    localparam int CW   = cnt_w(index_width);
    localparam logic [CW-1:0] LAST = CW'(index_width - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [width-1:0] wrk  [0:index-1];
    logic [width-1:0] nxt  [0:index-1];
    logic [width-1:0] s_in [0:HALF-1];
    logic [width-1:0] d_in [0:HALF-1];
    logic [width-1:0] a_o  [0:HALF-1];
    logic [width-1:0] b_o  [0:HALF-1];

    for (genvar g = 0; g < HALF; g++) begin : g_bfly
        iht_butterfly #(.width(width)) u_bfly (
            .s(s_in[g]),
            .d(d_in[g]),
            .a(a_o[g]),
            .b(b_o[g])
        );
    end

    // Stage cnt works on L = 2 << cnt; pairs are (i, i + L/2).
    always_comb begin
        for (int i = 0; i < HALF; i++) begin
            s_in[i] = wrk[i];
            d_in[i] = wrk[i+HALF];
        end
        for (int k = 0; k < index_width; k++) begin
            if (cnt == CW'(k)) begin
                for (int i = 0; i < (1 << k); i++) begin
                    s_in[i] = wrk[i];
                    d_in[i] = wrk[i+(1<<k)];
                end
            end
        end
    end

    always_comb begin
        nxt = wrk;
        for (int k = 0; k < index_width; k++) begin
            if (cnt == CW'(k)) begin
                for (int i = 0; i < (1 << k); i++) begin
                    nxt[2*i]   = a_o[i];
                    nxt[2*i+1] = b_o[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            over  <= 1'b0;
            for (int i = 0; i < index; i++) begin
                wrk[i]     <= '0;
                outdata[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    over <= 1'b0;
                    if (start) begin
                        wrk   <= indata;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    wrk <= nxt;
                    if (cnt == LAST) begin
                        outdata <= nxt;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        over    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    over  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iht_inv.sv
// Bench for iht_inv: samples go through a forward Haar model, the DUT
// must return them bit-exactly with the expected handshake timing.
module tb_iht_inv;

    localparam int N = 8;

    typedef logic [7:0] vec_t [0:N-1];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    vec_t indata;
    vec_t outdata;
    logic busy;
    logic over;

    int checks = 0;
    int failures = 0;
    vec_t last_exp;

    iht_inv #(.index(8), .width(8), .index_width(3)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .indata(indata),
        .outdata(outdata),
        .busy(busy),
        .over(over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pk(input vec_t v);
        logic [63:0] r;
        for (int i = 0; i < N; i++) r[63-8*i -: 8] = v[i];
        return r;
    endfunction

    // Forward S-transform: finest level first, Mallat layout result.
    task automatic fwd(input vec_t x, output vec_t y);
        vec_t t;
        y = x;
        for (int l = N; l >= 2; l = l / 2) begin
            t = y;
            for (int i = 0; i < l / 2; i++) begin
                logic [7:0] a, b, d, s;
                a = t[2*i];
                b = t[2*i+1];
                d = a - b;
                s = b + 8'($signed(d) >>> 1);
                y[i] = s;
                y[i+l/2] = d;
            end
        end
    endtask

    task automatic rand_vec(output vec_t v);
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 5))
                0: v[i] = 8'h00;
                1: v[i] = 8'hFF;
                2: v[i] = 8'h7F;
                3: v[i] = 8'h80;
                default: v[i] = 8'($urandom);
            endcase
        end
    endtask

    task automatic run_vec(input vec_t coef, input vec_t exp, input string nm);
        int k;
        int bcnt;
        indata = coef;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        bcnt = 0;
        while (!over && k < 10) begin
            if (busy) bcnt++;
            tick();
            k++;
        end
        checks++;
        if (k !== 3) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=3", nm, k);
        end
        checks++;
        if (bcnt !== 3) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d want=3", nm, bcnt);
        end
        checks++;
        if (pk(outdata) !== pk(exp)) begin
            failures++;
            $display("FAIL %s_data got=%h want=%h", nm, pk(outdata), pk(exp));
        end
        last_exp = exp;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (pk(outdata) !== 64'h0) begin
            failures++;
            $display("FAIL reset_out got=%h want=0", pk(outdata));
        end
        checks++;
        if (busy !== 1'b0 || over !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b want=00", busy, over);
        end
        for (int i = 0; i < N; i++) last_exp[i] = 8'h00;
    endtask

    task automatic test_dc();
        vec_t c, e;
        for (int i = 0; i < N; i++) begin
            c[i] = 8'h00;
            e[i] = 8'h0A;
        end
        c[0] = 8'h0A;
        run_vec(c, e, "dc");
    endtask

    task automatic test_ramp();
        vec_t c, e;
        logic [63:0] cp;
        cp = 64'h04FCFEFEFFFFFFFF;
        for (int i = 0; i < N; i++) begin
            c[i] = cp[63-8*i -: 8];
            e[i] = 8'(i + 1);
        end
        run_vec(c, e, "ramp");
    endtask

    task automatic test_wrap();
        vec_t o, c;
        int bad = 0;
        for (int n = 0; n < 10000; n++) begin
            rand_vec(o);
            fwd(o, c);
            indata = c;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 0; k < 10 && !over; k++) tick();
            checks++;
            if (!over || pk(outdata) !== pk(o)) begin
                failures++;
                if (bad < 5)
                    $display("FAIL wrap_%0d got=%h want=%h over=%b",
                             n, pk(outdata), pk(o), over);
                bad++;
            end
            last_exp = o;
            tick();
        end
    endtask

    task automatic test_start_storm();
        vec_t orig [0:29];
        vec_t c;
        int free_at = 0;
        int acc = -1;
        int done_at = -1;
        int bad = 0;
        logic exp_over;
        for (int cy = 0; cy < 30; cy++) begin
            rand_vec(orig[cy]);
            fwd(orig[cy], c);
            indata = c;
            start = (cy < 20);
            if (start && cy >= free_at) begin
                acc = cy;
                free_at = cy + 5;
                done_at = cy + 3;
            end
            tick();
            exp_over = (cy == done_at);
            if (exp_over) last_exp = orig[acc];
            checks++;
            if (over !== exp_over || pk(outdata) !== pk(last_exp)) begin
                failures++;
                if (bad < 5)
                    $display("FAIL storm_cy%0d over=%b want=%b got=%h want=%h",
                             cy, over, exp_over, pk(outdata), pk(last_exp));
                bad++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        vec_t o, c;
        int seen = 0;
        rand_vec(o);
        fwd(o, c);
        indata = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || over !== 1'b0 || pk(outdata) !== 64'h0) begin
            failures++;
            $display("FAIL abort_state busy=%b over=%b out=%h want 0/0/0",
                     busy, over, pk(outdata));
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (over) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_no_over got=%0d pulses want=0", seen);
        end
        rand_vec(o);
        fwd(o, c);
        run_vec(c, o, "after_abort");
    endtask

    task automatic test_back_to_back();
        vec_t o1, c1, o2, c2;
        int k;
        rand_vec(o1);
        fwd(o1, c1);
        rand_vec(o2);
        fwd(o2, c2);
        indata = c1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 0; k < 10 && !over; k++) tick();
        checks++;
        if (!over || pk(outdata) !== pk(o1)) begin
            failures++;
            $display("FAIL b2b_first over=%b got=%h want=%h",
                     over, pk(outdata), pk(o1));
        end
        indata = c2;
        start = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ignored busy=%b want=0", busy);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept busy=%b want=1", busy);
        end
        for (k = 0; k < 10 && !over; k++) tick();
        checks++;
        if (k !== 3 || pk(outdata) !== pk(o2)) begin
            failures++;
            $display("FAIL b2b_second lat=%0d want=3 got=%h want=%h",
                     k, pk(outdata), pk(o2));
        end
        last_exp = o2;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) indata[i] = 8'h00;
        test_reset();
        test_dc();
        test_ramp();
        test_wrap();
        test_start_storm();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
